mem_access_engine: RTL and testbench

Parametrised successor to the MEM-stage data-memory front end. Owns the whole data-side wishbone transaction for one pipeline instruction: byte/word loads and stores, indirect accesses (pointer fetch then data access), and bounded RTY retry with error reporting. Sits in the MEM stage between the EX/MEM barrier and the D-cache wishbone port. Drives the MEM-stage stall request to the pipeline controller.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/wb_lane_steer.sv | 48 ++++
 rtl/mem_access_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_access_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and geometry helpers for the MEM-stage data-memory access engine.
// Line and lane geometry is derived from module parameters, so the helpers are
// functions. The localparams below give the geometry of the default build.
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PTR     = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } mem_access_state_t;

    function automatic int line_bytes(input int line_w);
        return line_w / 8;
    endfunction

    function automatic int byte_off_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int word_off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int lane_bits(input int line_w, input int data_w);
        return byte_off_bits(line_w) - word_off_bits(data_w);
    endfunction

    // Width of a counter that must be able to hold max_retry itself
    function automatic int retry_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

    localparam int LINE_BYTES    = line_bytes(128);
    localparam int LANE_BITS     = lane_bits(128, 16);
    localparam int BYTE_OFF_BITS = byte_off_bits(128);

endpackage

// File: rtl/wb_lane_steer.sv
// Lane steering between one DATA_W word (or byte) and a LINE_W wishbone line.
// Word accesses ignore the sub-word address bits, so they always land on an
// aligned lane. Byte reads are zero-extended to DATA_W.
module wb_lane_steer
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LINE_W = 128
) (
    input  logic [byte_off_bits(LINE_W)-1:0] addr_i,
    input  logic                             word_i,
    input  logic [DATA_W-1:0]                wdata_i,
    input  logic [LINE_W-1:0]                dat_s_i,
    output logic [LINE_W/8-1:0]              sel_o,
    output logic [LINE_W-1:0]                dat_m_o,
    output logic [DATA_W-1:0]                rdata_o
);

    localparam int OFF_W      = byte_off_bits(LINE_W);
    localparam int WORD_OFF   = word_off_bits(DATA_W);
    localparam int LB         = line_bytes(LINE_W);
    localparam int DATA_BYTES = DATA_W / 8;

    logic [OFF_W-1:0]  byte_off;
    logic [OFF_W+2:0]  bit_off;
    logic [LINE_W-1:0] shifted;

    assign byte_off = word_i ? {addr_i[OFF_W-1:WORD_OFF], {WORD_OFF{1'b0}}} : addr_i;
    assign bit_off  = {byte_off, 3'b000};
    assign shifted  = dat_s_i >> bit_off;

    // Place write data / byte enables at the addressed lane and pick read data out of it
    always_comb begin
        sel_o   = '0;
        dat_m_o = '0;
        rdata_o = '0;
        if (word_i) begin
            sel_o   = {{(LB-DATA_BYTES){1'b0}}, {DATA_BYTES{1'b1}}} << byte_off;
            dat_m_o = {{(LINE_W-DATA_W){1'b0}}, wdata_i} << bit_off;
            rdata_o = shifted[DATA_W-1:0];
        end else begin
            sel_o   = {{(LB-1){1'b0}}, 1'b1} << byte_off;
            dat_m_o = {{(LINE_W-8){1'b0}}, wdata_i[7:0]} << bit_off;
            rdata_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_engine.sv
// MEM-stage data-memory front end: owns one data-side wishbone transaction per
// instruction (byte/word load/store, optional pointer indirection, bounded RTY
// retry) and raises the MEM stall request while it is in flight.
// Build option: define MISALIGN_TRAP_EN to send misaligned word accesses (and
// misaligned fetched pointers) straight to ERR without a bus cycle; without it
// the sub-word address bits of a word access are ignored.
// DATA_W must be 16 or 32; LINE_W a power of two of at least 2*DATA_W.
//
// state   | meaning
// IDLE    | waiting for req_valid; latches the request on accept
// PTR     | reading the pointer word at the request address
// ACCESS  | data read/write at request address or fetched pointer
// BACKOFF | one idle bus cycle after RTY before re-entering PTR/ACCESS
// DONE    | result valid, held while stall=1
// ERR     | retry limit or misalignment trap, rdata=0, held while stall=1
module mem_access_engine
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int LINE_W    = 128,
    parameter int MAX_RETRY = 7
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     stall,
    input  logic                                     req_valid,
    input  logic                                     req_we,
    input  logic                                     req_word,
    input  logic                                     req_indirect,
    input  logic [ADDR_W-1:0]                        req_addr,
    input  logic [DATA_W-1:0]                        req_wdata,
    output logic [DATA_W-1:0]                        rdata,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     error,
    output logic [ADDR_W-byte_off_bits(LINE_W)-1:0]  wb_adr,
    output logic                                     wb_cyc,
    output logic                                     wb_stb,
    output logic                                     wb_we,
    output logic [LINE_W/8-1:0]                      wb_sel,
    output logic [LINE_W-1:0]                        wb_dat_m,
    input  logic [LINE_W-1:0]                        wb_dat_s,
    input  logic                                     wb_ack,
    input  logic                                     wb_rty
);

    localparam int OFF_W    = byte_off_bits(LINE_W);
    localparam int WORD_OFF = word_off_bits(DATA_W);
    localparam int RETRY_W  = retry_w(MAX_RETRY);

    mem_access_state_t state_q;

    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               we_q;
    logic               word_q;
    logic               ind_q;
    logic               phase_ptr_q;
    logic [RETRY_W-1:0] retry_cnt_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               done_q;
    logic               error_q;
    logic               cyc_q;
    logic               stb_q;
    logic               bus_we_q;

    logic [ADDR_W-1:0]   cur_addr;
    logic                cur_word;
    logic [LINE_W/8-1:0] steer_sel;
    logic [LINE_W-1:0]   steer_dat_m;
    logic [DATA_W-1:0]   lane_rdata;
    logic                trap_accept;
    logic                trap_ptr;

    // The pointer phase always reads a word at the request address; the data
    // phase of an indirect access goes to the fetched pointer instead.
    assign cur_addr = (ind_q && !phase_ptr_q) ? ptr_q : addr_q;
    assign cur_word = phase_ptr_q | word_q;

    wb_lane_steer #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) u_steer (
        .addr_i  (cur_addr[OFF_W-1:0]),
        .word_i  (cur_word),
        .wdata_i (wdata_q),
        .dat_s_i (wb_dat_s),
        .sel_o   (steer_sel),
        .dat_m_o (steer_dat_m),
        .rdata_o (lane_rdata)
    );

`ifdef MISALIGN_TRAP_EN
    // Indirect requests fetch a word at req_addr, so that address must be aligned too
    assign trap_accept = (req_word | req_indirect) & (|req_addr[WORD_OFF-1:0]);
    assign trap_ptr    = word_q & (|lane_rdata[WORD_OFF-1:0]);
`else
    assign trap_accept = 1'b0;
    assign trap_ptr    = 1'b0;
`endif

    assign busy     = (state_q == ST_PTR) || (state_q == ST_ACCESS) ||
                      (state_q == ST_BACKOFF) || ((state_q == ST_IDLE) && req_valid);
    assign rdata    = rdata_q;
    assign done     = done_q;
    assign error    = error_q;
    assign wb_cyc   = cyc_q;
    assign wb_stb   = stb_q;
    assign wb_we    = bus_we_q;
    assign wb_adr   = cur_addr[ADDR_W-1:OFF_W];
    assign wb_sel   = steer_sel;
    assign wb_dat_m = bus_we_q ? steer_dat_m : '0;

    // Transaction FSM with registered bus control and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            word_q      <= 1'b0;
            ind_q       <= 1'b0;
            phase_ptr_q <= 1'b0;
            retry_cnt_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            bus_we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        we_q        <= req_we;
                        word_q      <= req_word;
                        ind_q       <= req_indirect;
                        retry_cnt_q <= '0;
                        if (trap_accept) begin
                            state_q <= ST_ERR;
                            rdata_q <= '0;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q     <= req_indirect ? ST_PTR : ST_ACCESS;
                            phase_ptr_q <= req_indirect;
                            cyc_q       <= 1'b1;
                            stb_q       <= 1'b1;
                            bus_we_q    <= req_we & ~req_indirect;
                        end
                    end
                end
                ST_PTR, ST_ACCESS: begin
                    if (wb_ack) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        bus_we_q <= 1'b0;
                        if (state_q == ST_PTR) begin
                            ptr_q <= ADDR_W'(lane_rdata);
                            if (trap_ptr) begin
                                state_q <= ST_ERR;
                                rdata_q <= '0;
                                done_q  <= 1'b1;
                                error_q <= 1'b1;
                            end else begin
                                state_q     <= ST_ACCESS;
                                phase_ptr_q <= 1'b0;
                                cyc_q       <= 1'b1;
                                stb_q       <= 1'b1;
                                bus_we_q    <= we_q;
                            end
                        end else begin
                            if (!we_q) begin
                                rdata_q <= lane_rdata;
                            end
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (wb_rty) begin
                        cyc_q    <= 1'b0;
                        stb_q    <= 1'b0;
                        bus_we_q <= 1'b0;
                        if (retry_cnt_q == RETRY_W'(MAX_RETRY)) begin
                            state_q <= ST_ERR;
                            rdata_q <= '0;
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            state_q     <= ST_BACKOFF;
                        end
                    end
                end
                ST_BACKOFF: begin
                    state_q  <= phase_ptr_q ? ST_PTR : ST_ACCESS;
                    cyc_q    <= 1'b1;
                    stb_q    <= 1'b1;
                    bus_we_q <= we_q & ~phase_ptr_q;
                end
                ST_DONE, ST_ERR: begin
                    if (!stall) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_engine.sv
// Directed bench for mem_access_engine with a small wishbone slave model.
// Builds with or without MISALIGN_TRAP_EN; the misalignment vector adapts.
module tb_mem_access_engine;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int LINE_W    = 128;
    localparam int MAX_RETRY = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              stall = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic              req_word = 1'b0;
    logic              req_indirect = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              busy, done, error;
    logic [11:0]       wb_adr;
    logic              wb_cyc, wb_stb, wb_we;
    logic [15:0]       wb_sel;
    logic [127:0]      wb_dat_m;
    logic [127:0]      wb_dat_s = '0;
    logic              wb_ack = 1'b0;
    logic              wb_rty = 1'b0;

    mem_access_engine #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINE_W    (LINE_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_word     (req_word),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .wb_adr       (wb_adr),
        .wb_cyc       (wb_cyc),
        .wb_stb       (wb_stb),
        .wb_we        (wb_we),
        .wb_sel       (wb_sel),
        .wb_dat_m     (wb_dat_m),
        .wb_dat_s     (wb_dat_s),
        .wb_ack       (wb_ack),
        .wb_rty       (wb_rty)
    );

    always #5 clk = ~clk;

    // Slave model: read-only line memory, configurable ack delay and RTY budget.
    logic [127:0] line_mem [0:15];
    int           ack_delay = 0;
    int           rty_limit = 0;
    int           rty_total = 0;
    int           wait_cnt = 0;
    int           n_resp = 0;
    int           gap_cycles = 0;
    logic [11:0]  resp_adr [0:15];
    logic [15:0]  resp_sel = '0;
    logic [127:0] resp_dat_m = '0;
    logic         resp_we = 1'b0;

    always @(negedge clk) begin
        if (busy && !wb_stb && !req_valid) gap_cycles++;
        if (wb_ack || wb_rty) begin
            wb_ack   = 1'b0;
            wb_rty   = 1'b0;
            wait_cnt = 0;
        end else if (wb_cyc && wb_stb) begin
            if (wait_cnt >= ack_delay) begin
                resp_adr[n_resp % 16] = wb_adr;
                resp_sel   = wb_sel;
                resp_dat_m = wb_dat_m;
                resp_we    = wb_we;
                n_resp++;
                if (rty_total < rty_limit) begin
                    wb_rty = 1'b1;
                    rty_total++;
                end else begin
                    wb_ack   = 1'b1;
                    wb_dat_s = line_mem[wb_adr[3:0]];
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic word, input logic ind,
                         input logic [15:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        req_we       = we;
        req_word     = word;
        req_indirect = ind;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        #1;
        chk("busy_on_accept", busy, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        chk("done_seen", done, 1'b1);
    endtask

    int n0;
    int g0;

    initial begin
        for (int i = 0; i < 16; i++) line_mem[i] = '0;
        line_mem[0] = 128'h5A5A_0000;
        line_mem[1] = 128'h0042;
        line_mem[3] = 128'hBEEF_0000_0000_0000;
        line_mem[4] = 128'h1234_0000;

        // Reset values
        #2 rst_n = 1'b0;
        #10;
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stb", wb_stb, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Word load 0x0036: lane 3 of line 0x003
        ack_delay = 2;
        n0 = n_resp;
        issue(1'b0, 1'b1, 1'b0, 16'h0036, 16'h0);
        wait_done(40);
        chk("wl_sel", resp_sel, 16'h00C0);
        chk("wl_adr", resp_adr[n0 % 16], 12'h003);
        chk("wl_we", resp_we, 1'b0);
        chk("wl_rdata", rdata, 16'hBEEF);
        chk("wl_error", error, 1'b0);
        chk("wl_busy_done", busy, 1'b0);
        @(negedge clk);
        chk("wl_done_1cyc", done, 1'b0);

        // Byte store 0x0005
        ack_delay = 0;
        issue(1'b1, 1'b0, 1'b0, 16'h0005, 16'h12AB);
        wait_done(40);
        chk("bs_sel", resp_sel, 16'h0020);
        chk("bs_dat_m", resp_dat_m, 128'hAB00_0000_0000);
        chk("bs_we", resp_we, 1'b1);

        // Word store 0x0012
        issue(1'b1, 1'b1, 1'b0, 16'h0012, 16'hCAFE);
        wait_done(40);
        chk("ws_sel", resp_sel, 16'h000C);
        chk("ws_dat_m", resp_dat_m, 128'hCAFE_0000);

        // Indirect load: pointer at 0x0010 -> 0x0042 -> data 0x1234
        n0 = n_resp;
        issue(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        wait_done(40);
        chk("ind_bus_cycles", 32'(n_resp - n0), 32'd2);
        chk("ind_ptr_adr", resp_adr[n0 % 16], 12'h001);
        chk("ind_data_adr", resp_adr[(n0 + 1) % 16], 12'h004);
        chk("ind_rdata", rdata, 16'h1234);

        // Three RTYs then ack
        g0 = gap_cycles;
        rty_limit = rty_total + 3;
        issue(1'b0, 1'b1, 1'b0, 16'h0036, 16'h0);
        wait_done(60);
        chk("rty3_gaps", 32'(gap_cycles - g0), 32'd3);
        chk("rty3_error", error, 1'b0);
        chk("rty3_rdata", rdata, 16'hBEEF);

        // MAX_RETRY+1 RTYs -> error
        g0 = gap_cycles;
        rty_limit = rty_total + MAX_RETRY + 1;
        issue(1'b0, 1'b1, 1'b0, 16'h0036, 16'h0);
        wait_done(80);
        chk("rtymax_error", error, 1'b1);
        chk("rtymax_rdata", rdata, 16'h0);
        chk("rtymax_gaps", 32'(gap_cycles - g0), 32'(MAX_RETRY));
        rty_limit = rty_total;
        @(negedge clk);
        chk("rtymax_error_clear", error, 1'b0);

        // Completion under stall: byte load 0x0037 -> 0xBE, held 4 cycles
        stall = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 16'h0037, 16'h0);
        wait_done(40);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_done_held", done, 1'b1);
            chk("stall_rdata_held", rdata, 16'h00BE);
            chk("stall_no_accept", busy, 1'b0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("exit_done_low", done, 1'b0);
        chk("exit_no_cyc", wb_cyc, 1'b0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done(40);

        // Reset in the middle of ACCESS
        ack_delay = 20;
        issue(1'b0, 1'b1, 1'b0, 16'h0036, 16'h0);
        chk("pre_rst_cyc", wb_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cyc", wb_cyc, 1'b0);
        chk("midrst_stb", wb_stb, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_rdata", rdata, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        ack_delay = 0;

        // Misaligned word load at 0x0003
        n0 = n_resp;
        issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
        wait_done(40);
`ifdef MISALIGN_TRAP_EN
        chk("mis_no_bus", 32'(n_resp - n0), 32'd0);
        chk("mis_error", error, 1'b1);
        chk("mis_rdata", rdata, 16'h0);
`else
        chk("mis_sel", resp_sel, 16'h000C);
        chk("mis_adr", resp_adr[n0 % 16], 12'h000);
        chk("mis_rdata", rdata, 16'h5A5A);
        chk("mis_error", error, 1'b0);
`endif
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
